// File: rtl/qcl_pkg.sv
// Shared types for the qcl serial/parallel stages (register bank and PISO).
// QCL_ELEM_WORD_T(els, width) declares an els x width element word.
`ifndef QCL_ELEM_WORD_T
`define QCL_ELEM_WORD_T(els, width) logic [(els)-1:0][(width)-1:0]
`endif

package qcl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } qcl_piso_state_e;

    // Never returns zero, so a single-element word still gets a 1-bit index.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qcl_piso_buf.sv
// One els_p x width_p load-enable register bank with synchronous active-low clear.
module qcl_piso_buf
    import qcl_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            load_i,
    input  logic [els_p-1:0][width_p-1:0]   data_i,
    output logic [els_p-1:0][width_p-1:0]   data_o
);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_o <= '0;
        end else if (load_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/qcl_piso.sv
// Parallel-in, serial-out stage: takes an els_p-element word and emits it on valid/yumi.
// Optional QCL_PISO_PINGPONG_EN adds a shadow word so consecutive words stream without a bubble.
module qcl_piso
    import qcl_pkg::*;
#(
    parameter int width_p      = 8,
    parameter int els_p        = 4,
    parameter int addr_width_p = safe_clog2(els_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            v_i,
    input  logic [els_p-1:0][width_p-1:0]   data_i,
    output logic                            ready_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    output logic [addr_width_p-1:0]         addr_o,
    output logic                            last_o,
    input  logic                            yumi_i
);

    localparam int cnt_width_lp = safe_clog2(els_p);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(els_p - 1);

    typedef `QCL_ELEM_WORD_T(els_p, width_p) word_t;

    qcl_piso_state_e            state_r, state_n;
    logic [cnt_width_lp-1:0]    cnt_r, cnt_n;
    word_t                      main_q, main_d;
    logic                       main_load;
    logic                       is_last, take, take_last, accept, refill;

    assign is_last   = (cnt_r == cnt_last_lp);
    assign take      = (state_r == SEND) & yumi_i;
    assign take_last = take & is_last;
    assign accept    = v_i & ready_o;

`ifdef QCL_PISO_PINGPONG_EN
    word_t  shadow_q;
    logic   shadow_v_r, shadow_v_n, shadow_load;

    // A word arriving on the final handshake goes straight to main instead.
    assign shadow_load = accept & (state_r == SEND) & ~take_last;

    qcl_piso_buf #(.width_p(width_p), .els_p(els_p)) shadow_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (shadow_load),
        .data_i    (data_i),
        .data_o    (shadow_q)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            shadow_v_r <= 1'b0;
        end else begin
            shadow_v_r <= shadow_v_n;
        end
    end

    always_comb begin
        shadow_v_n = shadow_v_r;
        if (take_last && shadow_v_r) begin
            shadow_v_n = 1'b0;
        end else if (shadow_load) begin
            shadow_v_n = 1'b1;
        end
    end

    assign main_d = shadow_v_r ? shadow_q : data_i;
    assign refill = take_last & (shadow_v_r | accept);
`else
    assign main_d = data_i;
    assign refill = 1'b0;
`endif

    assign main_load = ((state_r == IDLE) & v_i) | refill;

    qcl_piso_buf #(.width_p(width_p), .els_p(els_p)) main_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (main_load),
        .data_i    (main_d),
        .data_o    (main_q)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (v_i) begin
                    state_n = SEND;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                if (take_last) begin
                    cnt_n = '0;
                    if (!refill) begin
                        state_n = IDLE;
                    end
                end else if (take) begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        v_o     = 1'b0;
        ready_o = 1'b1;
        data_o  = '0;
        addr_o  = '0;
        last_o  = 1'b0;
        if (state_r == SEND) begin
            v_o    = 1'b1;
            data_o = main_q[cnt_r];
            addr_o = addr_width_p'(cnt_r);
            last_o = is_last;
`ifdef QCL_PISO_PINGPONG_EN
            ready_o = ~shadow_v_r;
`else
            ready_o = 1'b0;
`endif
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("qcl_piso: yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_qcl_piso.sv
// Scoreboard bench for qcl_piso: a 4-element and a 1-element instance, width 8.
// Define QCL_PISO_PINGPONG_EN to exercise the back-to-back streaming build.
`timescale 1ns/1ps
module tb_qcl_piso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            v4, y4, r4, vo4, last4;
    logic [3:0][7:0] d4;
    logic [7:0]      do4;
    logic [1:0]      a4;
    logic            v1, y1, r1, vo1, last1;
    logic [0:0][7:0] d1;
    logic [7:0]      do1;
    logic [0:0]      a1;

    qcl_piso #(.width_p(8), .els_p(4), .addr_width_p(2)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v4), .data_i(d4), .ready_o(r4),
        .v_o(vo4), .data_o(do4), .addr_o(a4), .last_o(last4), .yumi_i(y4)
    );

    qcl_piso #(.width_p(8), .els_p(1), .addr_width_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .data_i(d1), .ready_o(r1),
        .v_o(vo1), .data_o(do1), .addr_o(a1), .last_o(last1), .yumi_i(y1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] a;
        logic       l;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [3:0][7:0] w);
        for (int i = 0; i < 4; i++) begin
            q4.push_back(exp_t'{d: w[i], a: 2'(i), l: (i == 3)});
        end
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (q4.size() != 0) begin
            fail("dut4 drain timeout");
            q4.delete();
        end
        y4 = 1'b0;
    endtask

    // Monitors: compare whatever is presented against the head; pop on handshake.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (reset_n && vo4) begin
            if (q4.size() == 0) begin
                fail("dut4 unexpected v_o");
            end else begin
                e = q4[0];
                chk("dut4 data_o", 32'(do4), 32'(e.d));
                chk("dut4 addr_o", 32'(a4), 32'(e.a));
                chk("dut4 last_o", 32'(last4), 32'(e.l));
                if (y4) void'(q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (reset_n && vo1) begin
            if (q1.size() == 0) begin
                fail("dut1 unexpected v_o");
            end else begin
                e = q1[0];
                chk("dut1 data_o", 32'(do1), 32'(e.d));
                chk("dut1 addr_o", 32'(a1), 32'(e.a));
                chk("dut1 last_o", 32'(last1), 32'(e.l));
                if (y1) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        v4 = 1'b0; y4 = 1'b0; d4 = '0;
        v1 = 1'b0; y1 = 1'b0; d1 = '0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle v_o", 32'(vo4), 0);
            chk("idle ready_o", 32'(r4), 1);
            chk("idle addr_o", 32'(a4), 0);
            chk("idle data_o", 32'(do4), 0);
            chk("idle last_o", 32'(last4), 0);
            chk("idle dut1 v_o", 32'(vo1), 0);
            tick();
        end

        // Basic word
        d4 = {8'h44, 8'h33, 8'h22, 8'h11};
        v4 = 1'b1;
        push4(d4);
        @(negedge clk);
        chk("basic no comb v_i->v_o", 32'(vo4), 0);
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        @(negedge clk);
        chk("basic latency v_o", 32'(vo4), 1);
`ifndef QCL_PISO_PINGPONG_EN
        chk("basic ready_o in SEND", 32'(r4), 0);
`endif
        drain4();
        @(negedge clk);
        chk("basic v_o after last", 32'(vo4), 0);
        chk("basic ready_o after last", 32'(r4), 1);

        // Backpressure at addr 2
        tick();
        v4 = 1'b1;
        push4(d4);
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        tick();
        tick();
        y4 = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("stall addr_o", 32'(a4), 2);
        chk("stall data_o", 32'(do4), 32'h33);
        tick();
        y4 = 1'b1;
        drain4();

        // Reset mid-transfer
        v4 = 1'b1;
        push4(d4);
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        tick();
        reset_n = 1'b0;
        y4 = 1'b0;
        q4.delete();
        tick();
        @(negedge clk);
        chk("midrst v_o", 32'(vo4), 0);
        chk("midrst ready_o", 32'(r4), 1);
        chk("midrst addr_o", 32'(a4), 0);
        chk("midrst data_o", 32'(do4), 0);
        tick();
        reset_n = 1'b1;
        d4 = {8'h88, 8'h77, 8'h66, 8'h55};
        v4 = 1'b1;
        push4(d4);
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        @(negedge clk);
        chk("midrst reload addr_o", 32'(a4), 0);
        chk("midrst reload data_o", 32'(do4), 32'h55);
        drain4();

`ifndef QCL_PISO_PINGPONG_EN
        // A word offered while busy is dropped
        tick();
        d4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        v4 = 1'b1;
        push4(d4);
        tick();
        d4 = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        drain4();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("dropped word stays idle", 32'(vo4), 0);
            tick();
        end
`else
        // Ping-pong: word B during SEND streams right behind word A
        tick();
        d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        v4 = 1'b1;
        push4(d4);
        tick();
        v4 = 1'b0;
        y4 = 1'b1;
        tick();
        d4 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        v4 = 1'b1;
        push4(d4);
        @(negedge clk);
        chk("pp ready_o before B", 32'(r4), 1);
        tick();
        v4 = 1'b0;
        @(negedge clk);
        chk("pp ready_o shadow full", 32'(r4), 0);
        chk("pp v_o stream", 32'(vo4), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pp v_o stream", 32'(vo4), 1);
        end
        drain4();
        @(negedge clk);
        chk("pp v_o after B", 32'(vo4), 0);
`endif

        // Single-element word
        tick();
        for (int k = 0; k < 2; k++) begin
            d1[0] = (k == 0) ? 8'hA5 : 8'h5A;
            v1 = 1'b1;
            q1.push_back(exp_t'{d: d1[0], a: 2'd0, l: 1'b1});
            tick();
            v1 = 1'b0;
            @(negedge clk);
            chk("els1 v_o", 32'(vo1), 1);
            chk("els1 last_o", 32'(last1), 1);
            tick();
            y1 = 1'b1;
            tick();
            y1 = 1'b0;
            @(negedge clk);
            chk("els1 v_o after yumi", 32'(vo1), 0);
            chk("els1 ready_o after yumi", 32'(r1), 1);
            tick();
        end

        chk("dut4 queue empty", 32'(q4.size()), 0);
        chk("dut1 queue empty", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qcl_piso.md
Name: qcl_piso

Overview:
- Parallel-in, serial-out stage. Sits directly downstream of the serial-write/parallel-out register bank.
- Accepts one word of els_p elements of width_p bits each when the upstream bank signals complete (its v_o drives this block's v_i).
- Emits the elements one per handshake, in index order 0..els_p-1, on a valid/yumi interface with element address and last flag.
- Used to re-serialise assembled configuration or data words toward a narrow consumer, e.g. a link or scan chain.

Parameters:
- width_p, "inv", bits per element.
- els_p, "inv", elements per parallel word; must be >= 1.
- addr_width_p, `BSG_SAFE_CLOG2(els_p), width of addr_o; must be >= clog2(els_p).

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  synchronous active-low reset.
- v_i  input  1  parallel word valid.
- data_i  input  [els_p-1:0][width_p-1:0]  parallel word; element 0 is sent first.
- ready_o  output  1  block can accept a word this cycle.
- v_o  output  1  serial element valid.
- data_o  output  width_p  current element.
- addr_o  output  addr_width_p  index of current element.
- last_o  output  1  current element is index els_p-1.
- yumi_i  input  1  consumer takes the current element; legal only when v_o=1.

Behaviour:
- Single clock. Reset is synchronous, active-low: reset_n_i=0 sampled on a rising edge resets all state.
- Reset state:
  - FSM in IDLE, cnt=0, main buffer and shadow buffer all zero, shadow_v=0.
  - Outputs: v_o=0, ready_o=1, addr_o=0, last_o=0, data_o=0.
- Reset asserted mid-transfer aborts the transfer with no further v_o. The partial word is discarded.
- IDLE state:
  - ready_o=1, v_o=0.
  - v_i=1 loads data_i into the main buffer, clears cnt and moves to SEND.
  - v_o rises the cycle after the load (1-cycle latency). There is no combinational path from v_i to v_o.
- SEND state:
  - v_o=1, data_o=main[cnt], addr_o=cnt (zero-extended), last_o=(cnt==els_p-1).
  - Outputs hold stable until yumi_i=1.
  - yumi_i=1 with last_o=0: cnt increments.
  - yumi_i=1 with last_o=1: go to IDLE, cnt=0.
  - Base build: ready_o=0 throughout SEND. v_i=1 while ready_o=0 is dropped; the upstream must not assert it.
- els_p=1: last_o=1 on every element; each word takes one handshake.
- Throughput (base build): one word per els_p+1 cycles minimum, because of the IDLE cycle between words.
- Illegal input: yumi_i=1 while v_o=0 is flagged by a simulation-only assertion and otherwise ignored. cnt is unchanged.
- cnt width is `BSG_SAFE_CLOG2(els_p). cnt never exceeds els_p-1; there is no wrap other than the reset to 0 on last.

Optional Feature:
- Macro: QCL_PISO_PINGPONG_EN
- Defined: adds a shadow buffer with valid bit shadow_v. In SEND, ready_o = ~shadow_v.
  - v_i accepted in SEND with no last yumi that cycle: write the shadow buffer, set shadow_v.
  - Last yumi with shadow_v=1: copy shadow to main, clear shadow_v, cnt=0, stay in SEND. No bubble between words.
  - Last yumi with shadow_v=0 and v_i=1 in the same cycle: load data_i directly into main, cnt=0, stay in SEND.
  - Last yumi with shadow_v=0 and v_i=0: go to IDLE.
  - Sustained throughput is one element per cycle.
- Undefined: behaviour is the base build above; no shadow registers are instantiated.

Decomposition:
- Shared package qcl_pkg:
  - typedef qcl_piso_state_e {IDLE, SEND}
  - parameterised element-word typedef helper, shared with the upstream register bank.
- Sub-module qcl_piso_buf: one els_p x width_p load-enable register bank with synchronous active-low clear.
  - Instantiated once for main, and a second time for shadow when QCL_PISO_PINGPONG_EN is defined.

Test Plan:
- Reset then idle: hold reset_n_i=0 for 3 cycles, release -> v_o=0, ready_o=1, addr_o=0 for 5 idle cycles.
- Basic word, with width_p=8, els_p=4, yumi_i held 1:
  - load data_i={8'h44,8'h33,8'h22,8'h11} -> next cycle v_o=1.
  - data_o sequence is 11,22,33,44 with addr_o 0,1,2,3.
  - last_o=1 only on 44; v_o=0 in the following cycle.
- Backpressure:
  - same word, yumi_i=0 for 4 cycles at addr 2 -> data_o stays 33, addr_o stays 2.
  - resume -> 33 then 44, with no element lost or duplicated.
- Reset mid-transfer: reset_n_i=0 while addr_o=1 -> next cycle v_o=0, ready_o=1; a new load then starts at addr_o=0 with the new data.
- els_p=1: load 8'hA5 -> one cycle later v_o=1, data_o=A5, last_o=1; after yumi, back to IDLE.
- PINGPONG_EN build: load word A at cycle 0 and word B at cycle 2 during SEND -> ready_o drops to 0, and the 8 elements stream back-to-back with v_o continuously 1 (A0..A3 then B0..B3).
